mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  HI/LO multiply-divide unit beside the execute stage. Takes operands and a one-hot op from EXE,
//  runs multi-cycle MULT/MULTU/DIV/DIVU, serves MTHI/MTLO writes and MFHI/MFLO reads.
//  Owns architectural HI/LO. Its busy output drives EXE's ready term, stalling the pipeline.
// PARAMETERS
//  MUL_LAT   2    cycles from MULT/MULTU accept to HI/LO update (>=1)
//  DATA_W    32   operand width; HI/LO width
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       asynchronous reset, active-high
//  md_op_in          in   6       one-hot {mtlo,mthi,divu,div,multu,mult}; all-zero = no op
//  md_in0_in         in   32      operand 0 (rs): dividend / multiplicand / MTHI-MTLO data
//  md_in1_in         in   32      operand 1 (rt): divisor / multiplier
//  md_cancel_in      in   1       exception flush; aborts the in-flight op
//  md_read_req_in    in   1       MFHI/MFLO read request
//  md_read_sel_in    in   1       1 = HI, 0 = LO
//  md_busy_out       out  1       op in flight; EXE holds ready low
//  md_rdata_out      out  32      selected HI/LO for MFHI/MFLO
//  md_rdata_valid_out out 1       md_rdata_out usable this cycle
//  md_hi_out         out  32      current HI register
//  md_lo_out         out  32      current LO register
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; HI=LO=0; busy=0; rdata_valid=0; divider counter=0.
//  - States: IDLE, MUL, DIV, FIX. Ops are accepted only in IDLE. Op inputs are sampled once, on the
//    accept edge. While busy, EXE holds its inputs stable, and new ops are ignored.
//  - MTHI/MTLO in IDLE: HI/LO written at the next edge; state stays IDLE; busy stays 0.
//  - MULT/MULTU: IDLE->MUL. Product is 64-bit signed/unsigned, registered {HI,LO}.
//    Update occurs MUL_LAT edges after accept; busy=1 for exactly MUL_LAT cycles; then IDLE.
//  - DIV/DIVU: IDLE->DIV. Restoring radix-2 on magnitudes, 32 iterations, counter 0..31.
//    DIV->FIX when counter==31. FIX applies signs, writes HI/LO, returns to IDLE.
//    Busy=1 for 33 cycles; HI/LO update on the 33rd edge after accept.
//  - Sign rules (signed ops): quotient sign = s0^s1; remainder sign = s0.
//  - Divide by zero: LO=32'hFFFF_FFFF (DIVU) or +/-all-ones per sign rule (DIV); HI=dividend.
//    Takes the full 33 cycles.
//  - 0x8000_0000 / -1 (DIV): LO=0x8000_0000, HI=0; no trap.
//  - md_busy_out is combinational from state: 1 in MUL/DIV/FIX. Accept cycle itself: busy=0.
//  - Reads: rdata_out = sel ? HI : LO, combinational. rdata_valid = read_req & ~busy.
//    A read asserted while busy waits; EXE is already stalled by busy.
//  - Write and read in the same IDLE cycle (MTxx + MFxx): read returns the OLD value.
//  - md_cancel_in:
//    - In MUL/DIV/FIX: next state IDLE; HI/LO unchanged; busy drops next cycle.
//    - With an op in IDLE: op not accepted; MTHI/MTLO suppressed.
//    - Cancel wins over the FIX writeback in the same cycle.
//  - Reset mid-operation: immediate IDLE, HI=LO=0, no partial writeback.
// STRUCTURE
//  - defines.vh gets:
//    - MD_OP_* bit indices (MULT=0 .. MTLO=5)
//    - MD_ST_* state encodings (2-bit)
//    - ini_md_hi / ini_md_lo reset constants
//  - Sub-module md_divider: iterative 32-step unsigned core.
//    - Ports: clk, rst, start, cancel, dividend, divisor, done, quot, rem.
//    - Sign pre/post handling stays in mul_div_unit.
//  - Multiplier: behavioural '*' on 33-bit sign/zero-extended operands, then a MUL_LAT-deep
//    register pipe.
// TESTING
//  1 MTHI 0x1234_5678, then MFHI next cycle -> rdata=0x1234_5678, valid=1, busy never asserted.
//  2 MULT 0xFFFF_FFFE x 3 -> busy 2 cycles; then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
//    MULTU same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
//  3 DIV -7 / 2 -> busy 33 cycles; LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
//    DIVU 100/7 -> LO=14, HI=2.
//  4 DIVU 5 / 0 -> LO=0xFFFF_FFFF, HI=5 after 33 cycles.
//    DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
//  5 DIV 100/7, md_cancel_in at cycle 10 -> busy=0 at cycle 11; HI/LO keep prior values;
//    following MULTU 3x4 -> LO=12.
//  6 MFLO requested during DIV -> valid=0 until busy falls; then new LO on the same cycle.
//    Async rst mid-DIV -> HI=LO=0 before next edge.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op bit positions,
// FSM state encodings and reset constants for the architectural HI/LO pair.
package mul_div_unit_pkg;

   localparam int MD_OP_MULT  = 0;
   localparam int MD_OP_MULTU = 1;
   localparam int MD_OP_DIV   = 2;
   localparam int MD_OP_DIVU  = 3;
   localparam int MD_OP_MTHI  = 4;
   localparam int MD_OP_MTLO  = 5;
   localparam int MD_OP_W     = 6;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'd0,
      MD_ST_MUL  = 2'd1,
      MD_ST_DIV  = 2'd2,
      MD_ST_FIX  = 2'd3
   } md_state_e;

   localparam logic [31:0] INI_MD_HI = 32'h0000_0000;
   localparam logic [31:0] INI_MD_LO = 32'h0000_0000;

   // Every non-IDLE state holds the pipeline.
   function automatic logic md_busy_state(input md_state_e st);
      return (st != MD_ST_IDLE);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Bundle between EXE and the multiply-divide unit: op offer, read port,
// HI/LO visibility and the FSM state for observation.
interface mul_div_unit_if #(
   parameter int DATA_W = 32
);
   import mul_div_unit_pkg::*;

   // Handshake: EXE offers md_op_in; the unit takes it only on an edge where
   // md_busy_out is low and md_cancel_in is low, and ignores ops while busy.
   // A read is served when md_read_req_in is high and md_busy_out is low,
   // which is exactly when md_rdata_valid_out is high.
   logic [MD_OP_W-1:0] md_op_in;
   logic [DATA_W-1:0]  md_in0_in;
   logic [DATA_W-1:0]  md_in1_in;
   logic               md_cancel_in;
   logic               md_read_req_in;
   logic               md_read_sel_in;
   logic               md_busy_out;
   logic [DATA_W-1:0]  md_rdata_out;
   logic               md_rdata_valid_out;
   logic [DATA_W-1:0]  md_hi_out;
   logic [DATA_W-1:0]  md_lo_out;
   md_state_e          md_state_out;

   modport master (
      output md_op_in, md_in0_in, md_in1_in, md_cancel_in,
      output md_read_req_in, md_read_sel_in,
      input  md_busy_out, md_rdata_out, md_rdata_valid_out,
      input  md_hi_out, md_lo_out, md_state_out
   );

   modport slave (
      input  md_op_in, md_in0_in, md_in1_in, md_cancel_in,
      input  md_read_req_in, md_read_sel_in,
      output md_busy_out, md_rdata_out, md_rdata_valid_out,
      output md_hi_out, md_lo_out, md_state_out
   );

endinterface

// File: rtl/mul_div_unit_divider.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per cycle,
// W steps, done flags the cycle in which the last step is taken.
module md_divider #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cancel,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem
);

   localparam int CNT_W = $clog2(W);

   logic             r_run;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_quot;
   logic [W-1:0]     r_rem;
   logic [W-1:0]     r_dvs;
   logic [W:0]       w_shift;
   logic [W:0]       w_diff;
   logic             w_last;

   // Partial remainder stays below the divisor, so the shifted value fits W+1 bits.
   assign w_shift = {r_rem, r_quot[W-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_last  = (r_cnt == CNT_W'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
      end else if (cancel) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (start) begin
         r_run  <= 1'b1;
         r_cnt  <= '0;
         r_quot <= dividend;
         r_rem  <= '0;
         r_dvs  <= divisor;
      end else if (r_run) begin
         if (!w_diff[W]) begin
            r_rem  <= w_diff[W-1:0];
            r_quot <= {r_quot[W-2:0], 1'b1};
         end else begin
            r_rem  <= w_shift[W-1:0];
            r_quot <= {r_quot[W-2:0], 1'b0};
         end
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_run <= 1'b0;
         end
      end
   end

   assign done = r_run & w_last;
   assign quot = r_quot;
   assign rem  = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit beside EXE: multi-cycle MULT/MULTU/DIV/DIVU,
// MTHI/MTLO writes and MFHI/MFLO reads; busy stalls the pipeline.
module mul_div_unit #(
   parameter int MUL_LAT = 2,
   parameter int DATA_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   mul_div_unit_if.slave  md
);
   import mul_div_unit_pkg::*;

   localparam int PW   = 2 * DATA_W;
   localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   md_state_e          r_state;
   md_state_e          w_state_nxt;
   logic [DATA_W-1:0]  r_hi;
   logic [DATA_W-1:0]  r_lo;
   logic               w_hi_we;
   logic               w_lo_we;
   logic [DATA_W-1:0]  w_hi_wdata;
   logic [DATA_W-1:0]  w_lo_wdata;
   logic               w_start_mul;
   logic               w_start_div;
   logic               w_busy;
   logic               w_is_mul;
   logic               w_is_div;

   assign w_is_mul = md.md_op_in[MD_OP_MULT] | md.md_op_in[MD_OP_MULTU];
   assign w_is_div = md.md_op_in[MD_OP_DIV]  | md.md_op_in[MD_OP_DIVU];

   // Multiplier: 33-bit extended operands make one signed multiply cover both ops.
   logic signed [DATA_W:0] w_mul_a;
   logic signed [DATA_W:0] w_mul_b;
   logic [PW-1:0]          w_mul_prod;
   logic [PW-1:0]          r_mul_pipe [MUL_LAT];
   logic [MC_W-1:0]        r_mul_cnt;
   logic                   w_mul_last;

   assign w_mul_a    = {md.md_op_in[MD_OP_MULT] & md.md_in0_in[DATA_W-1], md.md_in0_in};
   assign w_mul_b    = {md.md_op_in[MD_OP_MULT] & md.md_in1_in[DATA_W-1], md.md_in1_in};
   assign w_mul_prod = PW'(w_mul_a) * PW'(w_mul_b);
   assign w_mul_last = (r_state == MD_ST_MUL) && (r_mul_cnt == MC_W'(MUL_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            r_mul_pipe[i] <= '0;
         end
         r_mul_cnt <= '0;
      end else if (w_start_mul) begin
         r_mul_pipe[0] <= w_mul_prod;
         r_mul_cnt     <= '0;
      end else if (r_state == MD_ST_MUL) begin
         for (int i = 1; i < MUL_LAT; i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
         end
         r_mul_cnt <= r_mul_cnt + 1'b1;
      end
   end

   // Divider runs on magnitudes; signs and the divide-by-zero case are applied in FIX.
   logic              w_s0;
   logic              w_s1;
   logic [DATA_W-1:0] w_mag0;
   logic [DATA_W-1:0] w_mag1;
   logic              r_div_s0;
   logic              r_div_qneg;
   logic              r_div_zero;
   logic [DATA_W-1:0] r_div_dividend;
   logic              w_div_done;
   logic [DATA_W-1:0] w_div_quot;
   logic [DATA_W-1:0] w_div_rem;
   logic [DATA_W-1:0] w_quot_mag;
   logic [DATA_W-1:0] w_fix_hi;
   logic [DATA_W-1:0] w_fix_lo;

   assign w_s0   = md.md_op_in[MD_OP_DIV] & md.md_in0_in[DATA_W-1];
   assign w_s1   = md.md_op_in[MD_OP_DIV] & md.md_in1_in[DATA_W-1];
   assign w_mag0 = w_s0 ? (~md.md_in0_in + 1'b1) : md.md_in0_in;
   assign w_mag1 = w_s1 ? (~md.md_in1_in + 1'b1) : md.md_in1_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_s0       <= 1'b0;
         r_div_qneg     <= 1'b0;
         r_div_zero     <= 1'b0;
         r_div_dividend <= '0;
      end else if (w_start_div) begin
         r_div_s0       <= w_s0;
         r_div_qneg     <= w_s0 ^ w_s1;
         r_div_zero     <= (md.md_in1_in == '0);
         r_div_dividend <= md.md_in0_in;
      end
   end

   md_divider #(
      .W (DATA_W)
   ) u_divider (
      .clk      (clk),
      .rst      (rst),
      .start    (w_start_div),
      .cancel   (md.md_cancel_in),
      .dividend (w_mag0),
      .divisor  (w_mag1),
      .done     (w_div_done),
      .quot     (w_div_quot),
      .rem      (w_div_rem)
   );

   assign w_quot_mag = r_div_zero ? '1 : w_div_quot;
   assign w_fix_lo   = r_div_qneg ? (~w_quot_mag + 1'b1) : w_quot_mag;
   assign w_fix_hi   = r_div_zero ? r_div_dividend :
                       (r_div_s0 ? (~w_div_rem + 1'b1) : w_div_rem);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= MD_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_mul = 1'b0;
      w_start_div = 1'b0;
      w_hi_we     = 1'b0;
      w_lo_we     = 1'b0;
      w_hi_wdata  = r_hi;
      w_lo_wdata  = r_lo;
      case (r_state)
         MD_ST_IDLE: begin
            if (!md.md_cancel_in) begin
               if (md.md_op_in[MD_OP_MTHI]) begin
                  w_hi_we    = 1'b1;
                  w_hi_wdata = md.md_in0_in;
               end else if (md.md_op_in[MD_OP_MTLO]) begin
                  w_lo_we    = 1'b1;
                  w_lo_wdata = md.md_in0_in;
               end else if (w_is_mul) begin
                  w_start_mul = 1'b1;
                  w_state_nxt = MD_ST_MUL;
               end else if (w_is_div) begin
                  w_start_div = 1'b1;
                  w_state_nxt = MD_ST_DIV;
               end
            end
         end
         MD_ST_MUL: begin
            if (md.md_cancel_in) begin
               w_state_nxt = MD_ST_IDLE;
            end else if (w_mul_last) begin
               w_state_nxt = MD_ST_IDLE;
               w_hi_we     = 1'b1;
               w_lo_we     = 1'b1;
               {w_hi_wdata, w_lo_wdata} = r_mul_pipe[MUL_LAT-1];
            end
         end
         MD_ST_DIV: begin
            if (md.md_cancel_in) begin
               w_state_nxt = MD_ST_IDLE;
            end else if (w_div_done) begin
               w_state_nxt = MD_ST_FIX;
            end
         end
         MD_ST_FIX: begin
            w_state_nxt = MD_ST_IDLE;
            if (!md.md_cancel_in) begin
               w_hi_we    = 1'b1;
               w_lo_we    = 1'b1;
               w_hi_wdata = w_fix_hi;
               w_lo_wdata = w_fix_lo;
            end
         end
         default: begin
            w_state_nxt = MD_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= DATA_W'(INI_MD_HI);
         r_lo <= DATA_W'(INI_MD_LO);
      end else begin
         if (w_hi_we) r_hi <= w_hi_wdata;
         if (w_lo_we) r_lo <= w_lo_wdata;
      end
   end

   assign w_busy                = md_busy_state(r_state);
   assign md.md_busy_out        = w_busy;
   assign md.md_rdata_out       = md.md_read_sel_in ? r_hi : r_lo;
   assign md.md_rdata_valid_out = md.md_read_req_in & ~w_busy;
   assign md.md_hi_out          = r_hi;
   assign md.md_lo_out          = r_lo;
   assign md.md_state_out       = r_state;

endmodule
